// File: rtl/evr_hardware_outputs_pkg.sv
// Shared constants for the EVR hardware trigger outputs: idle code,
// configuration-word field positions and the status word layout.
package evr_hardware_outputs_pkg;

    localparam int EVCODE_IDLE = 0;

    // Configuration word (GPIO_OUT) fields
    localparam int GPIO_WRITE_BIT  = 31;
    localparam int GPIO_TARGET_BIT = 30;
    localparam int GPIO_CHAN_MSB   = 18;
    localparam int GPIO_CHAN_LSB   = 16;
    localparam int GPIO_DATA_MSB   = 15;
    localparam int GPIO_DATA_LSB   = 0;

    // Status word layout: {hwOutputs, 5'b0, selected channel, readback}
    localparam int STATUS_OUT_LSB  = 24;
    localparam int STATUS_PAD_LSB  = 19;
    localparam int STATUS_CHAN_LSB = 16;
    localparam int STATUS_RB_LSB   = 0;

    localparam int CHAN_SEL_W = 3;
    localparam int PULSE_W    = 16;

    localparam logic TARGET_WIDTH = 1'b1;
    localparam logic TARGET_CODE  = 1'b0;

endpackage

// File: rtl/evr_hardware_outputs_pulse_channel.sv
// One trigger channel: programmable event code, pulse width and a
// retriggerable down-counter whose nonzero state is the output pulse.
module evr_pulse_channel
    import evr_hardware_outputs_pkg::*;
#(
    parameter int EVENTCODE_WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       event_accept,
    input  logic [EVENTCODE_WIDTH-1:0] event_code,
    input  logic                       wr_code,
    input  logic [EVENTCODE_WIDTH-1:0] wr_code_data,
    input  logic                       wr_width,
    input  logic [PULSE_W-1:0]         wr_width_data,
    output logic [EVENTCODE_WIDTH-1:0] code,
    output logic [PULSE_W-1:0]         width,
    output logic                       pulse
);

    logic [EVENTCODE_WIDTH-1:0] code_q, code_d;
    logic [PULSE_W-1:0]         width_q, width_d;
    logic [PULSE_W-1:0]         cnt_q, cnt_d;
    logic                       match;

    // Compare uses the registered code/width, so a write landing in the same
    // cycle as an event only affects later events.
    assign match = event_accept && (event_code == code_q) &&
                   (code_q != EVENTCODE_WIDTH'(EVCODE_IDLE));

    always_comb begin
        code_d  = code_q;
        width_d = width_q;
        cnt_d   = cnt_q;
        if (wr_code) code_d = wr_code_data;
        if (wr_width) width_d = wr_width_data;
        if (match) begin
            cnt_d = (width_q == '0) ? PULSE_W'(1) : width_q;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - PULSE_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            code_q  <= '0;
            width_q <= PULSE_W'(1);
            cnt_q   <= '0;
        end else begin
            code_q  <= code_d;
            width_q <= width_d;
            cnt_q   <= cnt_d;
        end
    end

    assign code  = code_q;
    assign width = width_q;
    assign pulse = (cnt_q != '0);

endmodule

// File: rtl/evr_hardware_outputs.sv
// EVR hardware trigger outputs: decodes accepted event codes into per-channel
// pulses and provides a CSR path to program and read back code/width per channel.
module evr_hardware_outputs
    import evr_hardware_outputs_pkg::*;
#(
    parameter int OUTPUT_COUNT    = 8,
    parameter int EVENTCODE_WIDTH = 8
) (
    input  logic                       evrClk,
    input  logic                       evrReset,
    input  logic                       csrStrobe,
    input  logic [31:0]                GPIO_OUT,
    output logic [31:0]                status,
    input  logic [EVENTCODE_WIDTH-1:0] evrEventTDATA,
    input  logic                       evrEventTVALID,
    output logic                       evrEventTREADY,
    output logic [OUTPUT_COUNT-1:0]    hwOutputs
);

    // Handshake: an event is consumed in any cycle where TVALID && TREADY;
    // TREADY is high whenever reset is not asserted.
    logic event_accept;
    assign evrEventTREADY = ~evrReset;
    assign event_accept   = evrEventTVALID & evrEventTREADY;

    logic                  cfg_write;
    logic                  cfg_target;
    logic [CHAN_SEL_W-1:0] cfg_chan;
    logic [PULSE_W-1:0]    cfg_data;
    logic                  gpio_unused;

    assign cfg_write   = csrStrobe & GPIO_OUT[GPIO_WRITE_BIT];
    assign cfg_target  = GPIO_OUT[GPIO_TARGET_BIT];
    assign cfg_chan    = GPIO_OUT[GPIO_CHAN_MSB:GPIO_CHAN_LSB];
    assign cfg_data    = GPIO_OUT[GPIO_DATA_MSB:GPIO_DATA_LSB];
    assign gpio_unused = ^GPIO_OUT[GPIO_TARGET_BIT-1:GPIO_CHAN_MSB+1];

    logic [EVENTCODE_WIDTH-1:0] code_arr  [OUTPUT_COUNT];
    logic [PULSE_W-1:0]         width_arr [OUTPUT_COUNT];

    for (genvar i = 0; i < OUTPUT_COUNT; i++) begin : g_chan
        logic sel_this;
        assign sel_this = cfg_write && (cfg_chan == CHAN_SEL_W'(i));

        evr_pulse_channel #(
            .EVENTCODE_WIDTH(EVENTCODE_WIDTH)
        ) u_chan (
            .clk          (evrClk),
            .rst          (evrReset),
            .event_accept (event_accept),
            .event_code   (evrEventTDATA),
            .wr_code      (sel_this && (cfg_target == TARGET_CODE)),
            .wr_code_data (cfg_data[EVENTCODE_WIDTH-1:0]),
            .wr_width     (sel_this && (cfg_target == TARGET_WIDTH)),
            .wr_width_data(cfg_data),
            .code         (code_arr[i]),
            .width        (width_arr[i]),
            .pulse        (hwOutputs[i])
        );
    end

    logic [CHAN_SEL_W-1:0] sel_chan_q, sel_chan_d;
    logic                  sel_target_q, sel_target_d;
    logic [PULSE_W-1:0]    readback_q, readback_d;

    // Select is latched on every strobe (read or write); readback follows a cycle later.
    always_comb begin
        sel_chan_d   = sel_chan_q;
        sel_target_d = sel_target_q;
        if (csrStrobe) begin
            sel_chan_d   = cfg_chan;
            sel_target_d = cfg_target;
        end
        if (sel_target_q == TARGET_WIDTH) begin
            readback_d = width_arr[sel_chan_q];
        end else begin
            readback_d = PULSE_W'(code_arr[sel_chan_q]);
        end
    end

    always_ff @(posedge evrClk) begin
        if (evrReset) begin
            sel_chan_q   <= '0;
            sel_target_q <= 1'b0;
            readback_q   <= '0;
        end else begin
            sel_chan_q   <= sel_chan_d;
            sel_target_q <= sel_target_d;
            readback_q   <= readback_d;
        end
    end

    assign status = {hwOutputs, 5'b0, sel_chan_q, readback_q};

endmodule

// File: doc/evr_hardware_outputs.md
EVR_HARDWARE_OUTPUTS -- requirements
Module: evr_hardware_outputs

Interface
REQ-001 SHALL have parameter OUTPUT_COUNT, default 8: number of hardware trigger outputs; only 8 is supported.
REQ-002 SHALL have parameter EVENTCODE_WIDTH, default 8: width of each event code.
REQ-003 SHALL have port evrClk, input, 1: the single clock; all logic is synchronous to its rising edge.
REQ-004 SHALL have port evrReset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port csrStrobe, input, 1: one-cycle configuration access strobe.
REQ-006 SHALL have port GPIO_OUT, input, 32: configuration word.
- [31] write
- [30] target select: 1 = pulse width, 0 = event code
- [18:16] channel
- [15:0] data; event code uses [EVENTCODE_WIDTH-1:0]
REQ-007 SHALL have port status, output, 32: {hwOutputs, 5'b0, selected channel, 16-bit readback}.
REQ-008 SHALL have port evrEventTDATA, input, EVENTCODE_WIDTH: received event code.
REQ-009 SHALL have port evrEventTVALID, input, 1: event code is valid.
REQ-010 SHALL have port evrEventTREADY, output, 1: block accepts the event code.
REQ-011 SHALL have port hwOutputs, output, OUTPUT_COUNT: hardware trigger pulses, active high.

Function
REQ-012 SHALL drive evrEventTREADY high in every cycle except while evrReset is asserted; an event is accepted when TVALID and TREADY are both high.
REQ-013 SHALL compare each accepted code against all channel codes in parallel; every channel whose code matches and is nonzero SHALL fire.
REQ-014 SHALL never let code 0 (idle) fire a channel; a channel whose programmed code is 0 is disabled.
REQ-015 On acceptance in cycle N, a matching channel's output SHALL be high from cycle N+1 for exactly W cycles, W being that channel's 16-bit width.
- W = 0 SHALL be treated as W = 1.
REQ-016 A match while a channel's pulse is active SHALL restart its count; the output SHALL stay high with no low gap, ending W cycles after the retrigger.
REQ-017 Each channel SHALL run an independent down-counter: load W on match, decrement while nonzero, output high while nonzero.
REQ-018 A CSR write (csrStrobe and [31]) SHALL update the selected register in the same cycle.
- Takes effect for events accepted from the next cycle onward.
- Does not alter a pulse already in progress.
REQ-019 On any csrStrobe, the channel and target select SHALL be latched for readback.
- status[15:0] SHALL show the selected register one cycle after the latch, zero-extended.
REQ-020 A write coincident with an event acceptance SHALL use the pre-write value for that event.

Reset
REQ-021 Reset SHALL:
- clear all event codes to 0;
- set all widths to 1;
- clear all counters;
- drive hwOutputs = 0 and evrEventTREADY = 0;
- clear the latched select and the readback.
REQ-022 Reset asserted mid-pulse SHALL drive outputs low in the next cycle; events presented during reset SHALL be neither accepted nor fire a channel.

Structure
REQ-023 A shared constants file SHALL hold EVCODE_IDLE, the GPIO field positions and the status field layout.
REQ-024 A per-channel sub-module, evr_pulse_channel, SHALL hold the code compare, width register and down-counter; it is instantiated OUTPUT_COUNT times.

Verification
REQ-025 Program ch2 code 0x2A, width 4; send 0x2A in cycle 10 -> hwOutputs[2] high in cycles 11-14 only; other outputs stay 0.
REQ-026 Program ch0 and ch5 with code 0x10, widths 1 and 3; send 0x10 -> ch0 high 1 cycle, ch5 high 3 cycles, both starting the same cycle.
REQ-027 Ch1 code 0x05, width 10; send 0x05 at cycle 0 and again at cycle 6 -> output continuously high in cycles 1-16.
REQ-028 Send 0x00 with all codes 0, then program ch3 width 0 and code 0x7F and send 0x7F -> no output for 0x00; a 1-cycle pulse for 0x7F.
REQ-029 Assert evrReset during a 100-cycle pulse -> output low next cycle; TREADY low during reset; after reset, the old code no longer fires.
REQ-030 Write ch4 code 0x33, then read with [30]=0, channel 4 -> status[15:0] = 0x0033 and status[18:16] = 4.
